// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state encoding, error codes and defaults for the frame controller
// Configuration macro: RX_FRAME_CHECKSUM_EN (adds the S_CSUM parser state)
// Contents:
//   rx_frame_state_t  parser state encoding
//   ERR_*             err_code values reported with frame_err
//   DEFAULT_SYNC_BYTE frame start marker used when SYNC_BYTE is not overridden
//   pack_entry        builds a {last, data} buffer entry
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_LEN  = 2'd1,
    S_PAY  = 2'd2
`ifdef RX_FRAME_CHECKSUM_EN
    ,
    S_CSUM = 2'd3
`endif
  } rx_frame_state_t;

  localparam logic [1:0] ERR_BADLEN  = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [8:0] pack_entry(input logic last, input logic [7:0] data);
    return {last, data};
  endfunction

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - DEPTH x WIDTH simple dual-port RAM with registered read
// Ports:
//   clk    in          clock
//   rst    in          synchronous active-high reset (clears the read register only)
//   we     in          write enable
//   waddr  in  AW      write address
//   wdata  in  WIDTH   write data
//   raddr  in  AW      read address, sampled every cycle
//   rdata  out WIDTH   registered read data
module frame_buf #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH),
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A one-byte frame can be written and committed at the same edge that
  // prefetches its slot, so the write data is forwarded on an address match.
  always_comb begin
    rdata_d = mem_q[raddr];
    if (we && (waddr == raddr)) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - sync hunt, length-prefixed frame parser with commit/rollback payload buffer
// Configuration macro: RX_FRAME_CHECKSUM_EN
//   defined   : frame = SYNC, LEN, payload, XOR checksum (checked in S_CSUM)
//   undefined : frame = SYNC, LEN, payload; commit right after the final payload byte
// Ports:
//   clk        in      system clock
//   rst        in      synchronous active-high reset
//   rx_valid   in      one-cycle received-byte strobe
//   rx_data    in  8   received byte
//   rx_idle    in      line gap; aborts a frame in progress
//   out_valid  out     committed byte available at the head
//   out_ready  in      consumer accepts the head byte
//   out_data   out 8   head payload byte
//   out_last   out     head byte ends its frame
//   frame_ok   out     pulse: frame committed
//   frame_err  out     pulse: frame discarded
//   err_code   out 2   cause of the last discard (badlen, checksum, timeout, overflow)
//   busy       out     parser is inside a frame
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN   = 64,
  parameter int         DEPTH     = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_idle,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit separates a full buffer from an empty one.
  localparam int PW = AW + 1;

  rx_frame_state_t state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    remaining_q, remaining_d;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          buf_we;
  logic [8:0]    buf_wdata;
  logic [8:0]    buf_rdata;
  logic          rd_fire;

  logic [PW-1:0] occupancy;
  logic [31:0]   free_entries;
  logic [31:0]   len_ext;

  // Occupancy counts tentative entries too, so a frame accepted at S_LEN
  // can always be written in full without passing the read pointer.
  assign occupancy    = wr_ptr_q - rd_ptr_q;
  assign free_entries = 32'(DEPTH) - 32'(occupancy);
  assign len_ext      = 32'(rx_data);

  // ------------------------------------------------------------------
  // Parser / write side
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    remaining_d  = remaining_q;
`ifdef RX_FRAME_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    buf_we       = 1'b0;
    buf_wdata    = pack_entry(remaining_q == 8'd1, rx_data);

    // A line gap inside a frame wins over any byte arriving in the same cycle.
    if ((state_q != S_HUNT) && rx_idle) begin
      state_d     = S_HUNT;
      wr_ptr_d    = commit_ptr_q;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end else if (rx_valid) begin
      case (state_q)
        S_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN;
          end
        end

        S_LEN: begin
          if ((rx_data == 8'd0) || (len_ext > 32'(MAX_LEN))) begin
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = ERR_BADLEN;
          end else if (len_ext > free_entries) begin
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVF;
          end else begin
            state_d     = S_PAY;
            remaining_d = rx_data;
`ifdef RX_FRAME_CHECKSUM_EN
            csum_d      = rx_data;
`endif
          end
        end

        S_PAY: begin
          buf_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + PW'(1);
          remaining_d = remaining_q - 8'd1;
`ifdef RX_FRAME_CHECKSUM_EN
          csum_d      = csum_q ^ rx_data;
          if (remaining_q == 8'd1) begin
            state_d = S_CSUM;
          end
`else
          if (remaining_q == 8'd1) begin
            state_d      = S_HUNT;
            commit_ptr_d = wr_ptr_q + PW'(1);
            frame_ok_d   = 1'b1;
          end
`endif
        end

`ifdef RX_FRAME_CHECKSUM_EN
        S_CSUM: begin
          state_d = S_HUNT;
          if (rx_data == csum_q) begin
            commit_ptr_d = wr_ptr_q;
            frame_ok_d   = 1'b1;
          end else begin
            wr_ptr_d    = commit_ptr_q;
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
`endif

        default: begin
          state_d = S_HUNT;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Read side: only committed entries are visible
  // ------------------------------------------------------------------
  assign out_valid = (rd_ptr_q != commit_ptr_q);
  assign rd_fire   = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HUNT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      remaining_q  <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
      csum_q       <= '0;
`endif
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_BADLEN;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      remaining_q  <= remaining_d;
`ifdef RX_FRAME_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  // The RAM prefetches the slot the read pointer will point at next cycle,
  // so the head byte is ready the same cycle out_valid rises.
  frame_buf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (9)
  ) u_frame_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (buf_wdata),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (buf_rdata)
  );

  assign out_data  = buf_rdata[7:0];
  assign out_last  = buf_rdata[8];
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard bench for uart_rx_frame_ctrl (frame-level reference model)
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         DEPTH   = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  localparam logic [1:0] E_BADLEN  = 2'd0;
  localparam logic [1:0] E_CSUM    = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_OVF     = 2'd3;

`ifdef RX_FRAME_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_idle;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE (SYNC),
    .MAX_LEN   (MAX_LEN),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_idle   (rx_idle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  typedef struct {
    bit         ok;
    logic [1:0] code;
    int         due;
  } ev_t;

  logic [8:0] exp_bytes[$];
  ev_t        exp_ev[$];
  logic [7:0] pl[$];
  ev_t        mon_ev;
  logic [8:0] mon_b;
  logic [1:0] last_code = E_BADLEN;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int gap_max     = 0;
  bit rdy_rand    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      last_code = E_BADLEN;
    end else begin
      if (exp_ev.size() > 0 && cyc > exp_ev[0].due) begin
        mon_ev = exp_ev.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_event: no pulse by cycle %0d, expected ok=%0d code=%0d", mon_ev.due, mon_ev.ok, mon_ev.code);
      end
      if (frame_ok || frame_err) begin
        check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'(0));
        if (exp_ev.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: ok=%0d err=%0d code=%0d with none expected", frame_ok, frame_err, err_code);
        end else begin
          mon_ev = exp_ev.pop_front();
          check("event_kind", 32'(frame_ok), 32'(mon_ev.ok));
          check("event_cycle", 32'(cyc), 32'(mon_ev.due));
          if (!mon_ev.ok) last_code = mon_ev.code;
          check("err_code", 32'(err_code), 32'(last_code));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: data 0x%0h last %0d with none expected", out_data, out_last);
        end else begin
          mon_b = exp_bytes.pop_front();
          check("out_data", 32'(out_data), 32'(mon_b[7:0]));
          check("out_last", 32'(out_last), 32'(mon_b[8]));
        end
      end
    end
  end

  // Random consumer back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (int'($urandom_range(0, gap_max))) tick();
  endtask

  task automatic push_ev(input bit ok, input logic [1:0] code);
    ev_t e;
    e.ok   = ok;
    e.code = code;
    e.due  = cyc + 1;
    exp_ev.push_back(e);
  endtask

  // 0 = accepted, 1 = bad length, 2 = does not fit in the free space
  function automatic int len_fate(input logic [7:0] len);
    if (len == 8'd0 || int'(len) > MAX_LEN) return 1;
    if (int'(len) > DEPTH - exp_bytes.size()) return 2;
    return 0;
  endfunction

  task automatic rand_pl(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  task automatic commit_expected(input logic [7:0] len);
    for (int i = 0; i < int'(len); i++) exp_bytes.push_back({(i == int'(len) - 1), pl[i]});
    push_ev(1'b1, E_BADLEN);
  endtask

  // Sends a complete frame from pl; a non-zero bad_mask corrupts the checksum.
  task automatic frame(input logic [7:0] len, input logic [7:0] bad_mask);
    logic [7:0] cs;
    int fate;
    send(SYNC);
    fate = len_fate(len);
    if (fate != 0) begin
      push_ev(1'b0, (fate == 1) ? E_BADLEN : E_OVF);
      send(len);
      return;
    end
    send(len);
    cs = len;
    for (int i = 0; i < int'(len); i++) begin
      cs ^= pl[i];
`ifndef RX_FRAME_CHECKSUM_EN
      if (i == int'(len) - 1) commit_expected(len);
`endif
      send(pl[i]);
    end
`ifdef RX_FRAME_CHECKSUM_EN
    if (bad_mask == 8'h00) commit_expected(len);
    else push_ev(1'b0, E_CSUM);
    send(cs ^ bad_mask);
`else
    if (bad_mask != 8'h00) cs = 8'h00;
`endif
  endtask

  // cut < 0: gap right after SYNC; otherwise gap after cut payload bytes
  task automatic timeout_frame(input logic [7:0] len, input int cut, input bit with_byte);
    int fate;
    send(SYNC);
    if (cut >= 0) begin
      fate = len_fate(len);
      if (fate != 0) begin
        push_ev(1'b0, (fate == 1) ? E_BADLEN : E_OVF);
        send(len);
        return;
      end
      send(len);
      for (int i = 0; i < cut; i++) send(8'($urandom));
    end
    push_ev(1'b0, E_TIMEOUT);
    rx_idle  = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'($urandom);
    tick();
    rx_idle  = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic wait_events();
    int n = 0;
    while (exp_ev.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("events_resolved", 32'(exp_ev.size()), 32'(0));
  endtask

  task automatic drain();
    int n = 0;
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    while ((exp_bytes.size() != 0 || exp_ev.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    tick();
    check("drain_empty", 32'(exp_bytes.size() + exp_ev.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_frame_ok"},  32'(frame_ok),  32'(0));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(0));
    check({tag, "_err_code"},  32'(err_code),  32'(0));
    check({tag, "_busy"},      32'(busy),      32'(0));
    check({tag, "_out_data"},  32'(out_data),  32'(0));
    check({tag, "_out_last"},  32'(out_last),  32'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int len;
    int cut;
    int kind;
    logic [7:0] nb;

    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    rx_idle   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Good frame 11 22 33
    out_ready = 1'b1;
    pl = {8'h11, 8'h22, 8'h33};
    frame(8'd3, 8'h00);
    drain();

`ifdef RX_FRAME_CHECKSUM_EN
    // Checksum 04 instead of 03
    pl = {8'h11, 8'h22, 8'h33};
    frame(8'd3, 8'h07);
    repeat (3) tick();
    @(negedge clk);
    check("csum_err_no_output", 32'(out_valid), 32'(0));
    tick();
    drain();
`endif

    // Timeout mid-payload, then a good frame
    timeout_frame(8'd4, 2, 1'b0);
    pl = {8'h44, 8'h55};
    frame(8'd2, 8'h00);
    timeout_frame(8'd3, 1, 1'b1);
    timeout_frame(8'd3, -1, 1'b0);
    drain();

    // Length errors and noise
    frame(8'd0, 8'h00);
    frame(8'(MAX_LEN + 1), 8'h00);
    frame(8'h41, 8'h00);
    send(8'h00);
    send(8'hFF);
    send(8'h12);
    pl = {8'h01};
    frame(8'd1, 8'h00);
    rx_idle = 1'b1;
    tick();
    tick();
    rx_idle = 1'b0;
    drain();

    // Overflow with the consumer stalled
    out_ready = 1'b0;
    rand_pl(12);
    frame(8'd12, 8'h00);
    rand_pl(8);
    frame(8'd8, 8'h00);
    rand_pl(4);
    frame(8'd4, 8'h00);
    rand_pl(1);
    frame(8'd1, 8'h00);
    wait_events();
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'(exp_bytes.size() != 0));
    tick();
    drain();

    // Reset mid-frame with committed data still buffered
    out_ready = 1'b0;
    rand_pl(5);
    frame(8'd5, 8'h00);
    wait_events();
    send(SYNC);
    send(8'd4);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    check("midframe_busy", 32'(busy), 32'(1));
    check("midframe_out_valid", 32'(out_valid), 32'(exp_bytes.size() != 0));
    tick();
    rst = 1'b1;
    exp_bytes.delete();
    tick();
    tick();
    @(negedge clk);
    check_reset_outputs("midreset");
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    pl = {8'hA5, 8'h5A, 8'h00};
    frame(8'd3, 8'h00);
    drain();

    // Randomized traffic with random back-pressure
    gap_max  = 2;
    rdy_rand = 1'b1;
    for (int it = 0; it < 250; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 4 || kind == 9) begin
        len = (kind == 9) ? MAX_LEN : int'($urandom_range(1, MAX_LEN));
        rand_pl(len);
        frame(8'(len), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      end else if (kind == 5) begin
        frame(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)), 8'h00);
      end else if (kind == 6) begin
        len = int'($urandom_range(1, MAX_LEN));
        cut = int'($urandom_range(0, len + CSUM_EXTRA)) - 1;
        timeout_frame(8'(len), cut, 1'($urandom_range(0, 1)));
      end else if (kind == 7) begin
        repeat (int'($urandom_range(1, 3))) begin
          nb = 8'($urandom);
          if (nb == SYNC) nb = 8'h00;
          send(nb);
        end
      end else begin
        rx_idle = 1'b1;
        tick();
        rx_idle = 1'b0;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
